decimate_comb: RTL
==================

Name: decimate_comb

Overview:
- Decimation and comb section of the CIC decimator; sits directly downstream of the last integrator stage.
- Keeps every R-th integrator output sample and discards the rest. R is programmable at run time.
- Passes the kept samples through STAGES cascaded comb stages, each computing y[n] = x[n] - x[n-DIFF_DELAY].
- Final result is MSB-truncated to the output width. Strobe-qualified data in and out, no backpressure.

Parameters:
- DATA_WIDTH_INP, 16, width of the integrator output (full CIC register growth already included).
- DATA_WIDTH_OUT, 16, output width; must be <= DATA_WIDTH_INP.
- STAGES, 3, number of comb stages (>= 1).
- DIFF_DELAY, 1, differential delay M in decimated samples (1 or 2).
- RATE_WIDTH, 8, width of the rate input.
- RATE_DEFAULT, 4, decimation rate loaded at reset (>= 1).
- USE_DSP, 1, when 1, each comb subtractor is tagged for DSP mapping. Function is identical either way.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- inp_samp_data  in  DATA_WIDTH_INP  signed integrator output.
- inp_samp_str  in  1  input sample valid, one cycle per sample.
- rate  in  RATE_WIDTH  unsigned decimation rate R.
- rate_str  in  1  loads rate when high.
- out_samp_data  out  DATA_WIDTH_OUT  signed comb output.
- out_samp_str  out  1  output valid, one-cycle pulse per output sample.
- cur_rate  out  RATE_WIDTH  active decimation rate.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset state:
  - out_samp_str=0, out_samp_data=0, cur_rate=RATE_DEFAULT.
  - Phase counter=0.
  - All comb delay-line registers and pipeline registers = 0.
  - Strobes present during reset are ignored.
- Rate register:
  - On rate_str, cur_rate <= (rate==0 ? 1 : rate).
  - The phase counter is cleared in the same cycle.
  - Comb delay lines are NOT cleared.
- Phase counter:
  - Counts accepted inp_samp_str, range 0..cur_rate-1.
  - On a strobe with count==cur_rate-1: capture inp_samp_data into the decimation register, pulse dec_str next cycle, wrap count to 0.
  - Otherwise count+1. No strobe means hold.
  - Gaps between strobes are arbitrary; only strobes count.
- Simultaneous rate_str and inp_samp_str:
  - The new rate applies and the coincident sample is the first sample of the new frame (count <= 1).
  - If the new effective rate is 1, that sample is kept.
- cur_rate==1: every input sample is kept.
- Comb stage k (k=1..STAGES):
  - Advances only on the strobe from stage k-1 (stage 0 = dec_str).
  - out_k <= x - delay_k[DIFF_DELAY-1]; delay line shifts in x.
  - Registered, strobe_k is strobe_{k-1} delayed 1 cycle.
- Arithmetic:
  - All comb arithmetic is DATA_WIDTH_INP wide, two's complement, with modular wrap and no saturation. This is mandatory: integrator wrap cancels here.
- Output:
  - out_samp_data = out_STAGES[DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT] (MSB-aligned truncation, no rounding).
  - Held between strobes.
- Latency: a kept input strobe in cycle t gives out_samp_str in cycle t+1+STAGES. Fixed; independent of rate.
- Throughput: one input per cycle sustained. Output rate = input strobe rate / cur_rate.
- Reset mid-operation: everything returns to the reset state next cycle. In-flight samples are dropped and no strobe is emitted for them.

Test Plan:
1. Impulse response. STAGES=3, M=1, R=1, widths 16/16. Input 1 then zeros, strobe every cycle -> out 1,-3,3,-1,0,0... First output strobe 4 cycles after the impulse strobe.
2. Decimation. STAGES=1, M=1, R=4. Ramp 0,1,2,... strobed every cycle -> kept samples 3,7,11,15 -> out 3,4,4,4. out_samp_str once per 4 inputs, 2 cycles after each 4th strobe.
3. Wrap-around. STAGES=1, M=1, R=1, widths 8/8. Kept samples 120 then -126 (wrapped 130) -> second output 10.
4. Rate change with coincident strobe. R=4 running; pulse rate_str with rate=2 together with an input strobe -> that sample counts as 1 of 2, and the next strobe is kept. rate=0 -> cur_rate=1.
5. Gapped strobes and M=2. STAGES=1, R=2. Random 1–5 cycle gaps between strobes; inputs decimate to 10,20,35,50 -> out 10,20,25,30. No output without strobes.
6. Mid-stream reset. Assert reset for 1 cycle while samples are in the pipeline -> next cycle out_samp_str=0, out_samp_data=0, cur_rate=RATE_DEFAULT. Repeat test 1 afterwards -> identical results (delay lines cleared).

Source files
------------

// File: rtl/decimate_comb_if.sv
// decimate_comb_if: strobe-qualified sample stream into and out of the CIC comb section
//   master: drives inp_samp_data/inp_samp_str, receives out_samp_data/out_samp_str
//   slave : receives inp_samp_data/inp_samp_str, drives out_samp_data/out_samp_str
interface decimate_comb_if #(
  parameter int DATA_WIDTH_INP = 16,
  parameter int DATA_WIDTH_OUT = 16
);
  logic [DATA_WIDTH_INP-1:0] inp_samp_data;
  logic                      inp_samp_str;
  logic [DATA_WIDTH_OUT-1:0] out_samp_data;
  logic                      out_samp_str;
  modport master (output inp_samp_data, inp_samp_str, input out_samp_data, out_samp_str);
  modport slave (input inp_samp_data, inp_samp_str, output out_samp_data, out_samp_str);
endinterface

// File: rtl/decimate_comb.sv
// decimate_comb: keeps every R-th integrator sample and runs it through STAGES comb stages
//   clk, reset : clock, synchronous active-high reset
//   samp       : sample stream (inp_samp_* in, out_samp_* out)
//   rate       : decimation rate R, loaded on rate_str (0 treated as 1)
//   cur_rate   : active decimation rate
module decimate_comb #(
  parameter int DATA_WIDTH_INP = 16,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int STAGES         = 3,
  parameter int DIFF_DELAY     = 1,
  parameter int RATE_WIDTH     = 8,
  parameter int RATE_DEFAULT   = 4,
  parameter int USE_DSP        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  decimate_comb_if.slave        samp,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic                  rate_str,
  output logic [RATE_WIDTH-1:0] cur_rate
);
  localparam int W = DATA_WIDTH_INP;
  logic [RATE_WIDTH-1:0] cnt, eff_rate, new_rate, base, cnt_nxt;
  logic                  keep, dec_str;
  logic [W-1:0]          dec_data;
  logic [W-1:0]          x [STAGES+1];
  logic                  s [STAGES+1];
  // A rate load restarts the frame, so a coincident sample is counted against the new rate.
  always_comb begin
    eff_rate = rate == '0 ? RATE_WIDTH'(1) : rate;
    new_rate = rate_str ? eff_rate : cur_rate;
    base     = rate_str ? '0 : cnt;
    keep     = samp.inp_samp_str && base == new_rate - RATE_WIDTH'(1);
    cnt_nxt  = !samp.inp_samp_str ? base : keep ? '0 : base + RATE_WIDTH'(1);
  end
  always_ff @(posedge clk)
    if (reset) begin
      cur_rate <= RATE_WIDTH'(RATE_DEFAULT);
      cnt      <= '0;
      dec_str  <= 1'b0;
      dec_data <= '0;
    end else begin
      cur_rate <= new_rate;
      cnt      <= cnt_nxt;
      dec_str  <= keep;
      if (keep) dec_data <= samp.inp_samp_data;
    end
  assign x[0] = dec_data;
  assign s[0] = dec_str;
  for (genvar k = 1; k <= STAGES; k++) begin : g_comb
    logic [W-1:0] dl [DIFF_DELAY];
    logic [W-1:0] y, diff;
    logic         ys;
    // Modular subtraction: integrator wrap-around cancels here, so no saturation.
    if (USE_DSP != 0) begin : g_dsp
      (* use_dsp = "yes" *) logic [W-1:0] d;
      assign d    = x[k-1] - dl[DIFF_DELAY-1];
      assign diff = d;
    end else begin : g_lut
      assign diff = x[k-1] - dl[DIFF_DELAY-1];
    end
    always_ff @(posedge clk)
      if (reset) begin
        y  <= '0;
        ys <= 1'b0;
        for (int i = 0; i < DIFF_DELAY; i++) dl[i] <= '0;
      end else begin
        ys <= s[k-1];
        if (s[k-1]) begin
          y     <= diff;
          dl[0] <= x[k-1];
          for (int i = 1; i < DIFF_DELAY; i++) dl[i] <= dl[i-1];
        end
      end
    assign x[k] = y;
    assign s[k] = ys;
  end
  assign samp.out_samp_data = x[STAGES][W-1 -: DATA_WIDTH_OUT];
  assign samp.out_samp_str  = s[STAGES];
endmodule
